sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Two-client arbiter in front of the single-port 16Mx16 SDRAM controller at 100 MHz.
- Shares the controller's address/read/write request port between client 0 and client 1.
- Holds a grant across back-to-back streaming so open-row bursts are not broken; forces a switch after MAX_BURST accepts for fairness.
- Tags every accepted read so each returning rd_valid/rd_data word reaches the client that issued it.

Parameters:
- ADDR_W, 24, word address width (row[23:11], bank[10:9], col[8:0]).
- DATA_W, 16, data width.
- RD_LAT, 4, cycles from mem_rd_ack to mem_rd_valid in the SDRAM controller.
- MAX_BURST, 64, accepts allowed per grant while the other client is waiting; range 1..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- cN_addr  in  ADDR_W  client N address, N=0,1.
- cN_rd_req  in  1  client N read request; held while streaming.
- cN_wr_req  in  1  client N write request.
- cN_wr_data  in  DATA_W  client N write data; must be valid the cycle after cN_wr_ack.
- cN_rd_ack  out  1  client N read address accepted.
- cN_wr_ack  out  1  client N write address accepted.
- cN_rd_valid  out  1  client N read data valid.
- cN_rd_data  out  DATA_W  client N read data; 0 when not valid.
- mem_addr  out  ADDR_W  to SDRAM addr.
- mem_rd_req  out  1  to SDRAM rd_req.
- mem_wr_req  out  1  to SDRAM wr_req.
- mem_wr_data  out  DATA_W  to SDRAM wr_data.
- mem_rd_ack  in  1  from SDRAM rd_ack (combinational accept).
- mem_wr_ack  in  1  from SDRAM next_wr_ack (combinational accept).
- mem_rd_valid  in  1  from SDRAM rd_valid.
- mem_rd_data  in  DATA_W  from SDRAM rd_data.

Behaviour:
- FSM states:
  - IDLE: no owner. mem_rd_req=mem_wr_req=0, mem_addr=0.
  - OWN0: client 0 owns the port.
  - OWN1: client 1 owns the port.
- Transitions:
  - IDLE -> OWNk when any client requests; k chosen round-robin. The last owner loses a tie; the rr pointer resets to favour client 0.
  - OWNk -> IDLE when cK_rd_req|cK_wr_req is 0 (sampled this cycle).
  - OWNk -> IDLE when burst_cnt reaches MAX_BURST and the other client is requesting.
  - IDLE always lasts exactly one cycle with no requests driven, so the controller returns to its NOP decision before the new owner's address appears.
- Mux rules:
  - In OWNk, mem_addr/mem_rd_req/mem_wr_req = client k inputs, combinationally.
  - cK_rd_ack = mem_rd_ack & OWNk, combinationally. cK_wr_ack is formed the same way from mem_wr_ack.
  - Non-owner acks are 0.
- burst_cnt (8 bit):
  - cleared on entry to OWNk;
  - incremented on each mem_rd_ack|mem_wr_ack in OWNk;
  - saturates at MAX_BURST.
- Write data:
  - wr_owner_q <= k when mem_wr_ack in OWNk.
  - mem_wr_data = cK_wr_data for K = wr_owner_q, one cycle after accept.
  - A grant change does not disturb the in-flight write word.
- Read tagging:
  - RD_LAT-deep shift register of {valid, owner}; pushed every cycle with {mem_rd_ack, current owner}.
  - At the tail, if valid: mem_rd_valid/mem_rd_data route to that owner's cN_rd_valid/cN_rd_data. The other client sees 0.
  - Reads still in flight across a switch are delivered to the issuing client.
- Error flag:
  - mem_rd_valid with the tail tag invalid, or tag valid with mem_rd_valid=0, is a protocol error.
  - It sets sticky internal err_q, visible in simulation; no port.
- Reset values: state=IDLE, rr pointer=0, burst_cnt=0, tag pipe cleared, wr_owner_q=0. All cN_* outputs 0; mem_rd_req=mem_wr_req=0.
- Reset mid-burst: tag pipe cleared, so any in-flight reads are dropped (not delivered).
- A client asserting both rd_req and wr_req is passed through unchanged; the controller gives read priority.

Optional Feature:
- Macro ARB_PRIORITY_EN.
- Defined: client 0 has strict priority.
  - IDLE always picks client 0 if it requests.
  - OWN1 -> IDLE as soon as c0 requests and burst_cnt >= 1.
  - MAX_BURST applies to OWN0 only.
- Undefined: round-robin as above.

Test Plan:
- Single client: c0 streams 8 reads at addr 0x000100.. -> 8 c0_rd_ack; 8 c0_rd_valid, each 4 cycles after its ack, data matching the model; c1 outputs stay 0.
- Contention: c0 and c1 both read continuously, MAX_BURST=4 -> grants alternate every 4 accepts with a 1-cycle IDLE gap; no rd_valid is misrouted.
- Switch during read flight: c0 issues 2 reads then drops; c1 writes 0xBEEF at 0x000200 -> c0 gets both words after the switch; SDRAM sees 0xBEEF the cycle after c1_wr_ack.
- Write burst: c1 writes 0x1111..0x1118 to consecutive columns -> model memory holds all 8 words; wr_owner_q stays 1.
- Reset: rst asserted 1 cycle with 3 reads in flight -> all outputs 0 the next cycle; no cN_rd_valid pulses afterwards; state IDLE.
- ARB_PRIORITY_EN: c1 streaming, c0 requests at cycle 10 -> IDLE at cycle 11, OWN0 at cycle 12.

Source files
------------

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-client grant arbiter with read-return tagging.
// Optional ARB_PRIORITY_EN: strict client 0 priority instead of round-robin.

module sdram_arbiter #(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 4,
  parameter int MAX_BURST = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic              c0_rd_req,
  input  logic              c0_wr_req,
  input  logic [DATA_W-1:0] c0_wr_data,
  output logic              c0_rd_ack,
  output logic              c0_wr_ack,
  output logic              c0_rd_valid,
  output logic [DATA_W-1:0] c0_rd_data,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic              c1_rd_req,
  input  logic              c1_wr_req,
  input  logic [DATA_W-1:0] c1_wr_data,
  output logic              c1_rd_ack,
  output logic              c1_wr_ack,
  output logic              c1_rd_valid,
  output logic [DATA_W-1:0] c1_rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic              mem_rd_ack,
  input  logic              mem_wr_ack,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  state_t            state_q, state_d;
  logic              rr_q, rr_d;
  logic [7:0]        burst_cnt_q, burst_cnt_d;
  logic              wr_owner_q, wr_owner_d;
  logic [RD_LAT-1:0] tag_v_q, tag_v_d;
  logic [RD_LAT-1:0] tag_o_q, tag_o_d;
  logic              err_q, err_d;

  logic req0, req1, own0, own1;
  logic accept, burst_full;
  logic tail_v, tail_o, hit;

  assign req0   = c0_rd_req | c0_wr_req;
  assign req1   = c1_rd_req | c1_wr_req;
  assign own0   = (state_q == OWN0);
  assign own1   = (state_q == OWN1);
  assign accept = mem_rd_ack | mem_wr_ack;

  always_comb begin
    mem_addr   = '0;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    if (own0) begin
      mem_addr   = c0_addr;
      mem_rd_req = c0_rd_req;
      mem_wr_req = c0_wr_req;
    end else if (own1) begin
      mem_addr   = c1_addr;
      mem_rd_req = c1_rd_req;
      mem_wr_req = c1_wr_req;
    end
  end

  assign c0_rd_ack   = mem_rd_ack & own0;
  assign c0_wr_ack   = mem_wr_ack & own0;
  assign c1_rd_ack   = mem_rd_ack & own1;
  assign c1_wr_ack   = mem_wr_ack & own1;
  assign mem_wr_data = wr_owner_q ? c1_wr_data : c0_wr_data;

  // burst_full looks at the count including this cycle's accept,
  // so the grant ends right after the MAX_BURST-th accept
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (state_q == IDLE) begin
      burst_cnt_d = 8'd0;
    end else if (accept && burst_cnt_q != BURST_MAX) begin
      burst_cnt_d = burst_cnt_q + 8'd1;
    end
  end

  assign burst_full = (burst_cnt_d == BURST_MAX);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
`ifdef ARB_PRIORITY_EN
        if (req0) begin
          state_d = OWN0;
          rr_d    = 1'b1;
        end else if (req1) begin
          state_d = OWN1;
          rr_d    = 1'b0;
        end
`else
        if (req0 && (!req1 || !rr_q)) begin
          state_d = OWN0;
          rr_d    = 1'b1;
        end else if (req1) begin
          state_d = OWN1;
          rr_d    = 1'b0;
        end
`endif
      end
      OWN0: begin
        if (!req0 || (burst_full && req1)) state_d = IDLE;
      end
      OWN1: begin
`ifdef ARB_PRIORITY_EN
        if (!req1 || (req0 && burst_cnt_q != 8'd0)) state_d = IDLE;
`else
        if (!req1 || (burst_full && req0)) state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign tail_v = tag_v_q[RD_LAT-1];
  assign tail_o = tag_o_q[RD_LAT-1];
  assign hit    = mem_rd_valid & tail_v;

  assign c0_rd_valid = hit & ~tail_o;
  assign c1_rd_valid = hit & tail_o;
  assign c0_rd_data  = c0_rd_valid ? mem_rd_data : '0;
  assign c1_rd_data  = c1_rd_valid ? mem_rd_data : '0;

  always_comb begin
    tag_v_d    = {tag_v_q[RD_LAT-2:0], mem_rd_ack & (own0 | own1)};
    tag_o_d    = {tag_o_q[RD_LAT-2:0], own1};
    wr_owner_d = wr_owner_q;
    if (mem_wr_ack && (own0 | own1)) wr_owner_d = own1;
    err_d      = err_q | (mem_rd_valid ^ tail_v);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      burst_cnt_q <= 8'd0;
      wr_owner_q  <= 1'b0;
      tag_v_q     <= '0;
      tag_o_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      burst_cnt_q <= burst_cnt_d;
      wr_owner_q  <= wr_owner_d;
      tag_v_q     <= tag_v_d;
      tag_o_q     <= tag_o_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed bench for sdram_arbiter with a small
// SDRAM controller model (4-cycle read latency, write data next cycle).

module tb_sdram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] c0_addr, c1_addr;
  logic        c0_rd_req, c0_wr_req, c1_rd_req, c1_wr_req;
  logic [15:0] c0_wr_data, c1_wr_data;
  logic        c0_rd_ack, c0_wr_ack, c0_rd_valid;
  logic        c1_rd_ack, c1_wr_ack, c1_rd_valid;
  logic [15:0] c0_rd_data, c1_rd_data;
  logic [23:0] mem_addr;
  logic        mem_rd_req, mem_wr_req;
  logic [15:0] mem_wr_data;
  logic        mem_rd_ack, mem_wr_ack, mem_rd_valid;
  logic [15:0] mem_rd_data;

  always #5 clk = ~clk;

  sdram_arbiter #(
    .ADDR_W(24), .DATA_W(16), .RD_LAT(4), .MAX_BURST(4)
  ) dut (
    .clk(clk), .rst(rst),
    .c0_addr(c0_addr), .c0_rd_req(c0_rd_req), .c0_wr_req(c0_wr_req),
    .c0_wr_data(c0_wr_data), .c0_rd_ack(c0_rd_ack), .c0_wr_ack(c0_wr_ack),
    .c0_rd_valid(c0_rd_valid), .c0_rd_data(c0_rd_data),
    .c1_addr(c1_addr), .c1_rd_req(c1_rd_req), .c1_wr_req(c1_wr_req),
    .c1_wr_data(c1_wr_data), .c1_rd_ack(c1_rd_ack), .c1_wr_ack(c1_wr_ack),
    .c1_rd_valid(c1_rd_valid), .c1_rd_data(c1_rd_data),
    .mem_addr(mem_addr), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .mem_wr_data(mem_wr_data), .mem_rd_ack(mem_rd_ack),
    .mem_wr_ack(mem_wr_ack), .mem_rd_valid(mem_rd_valid),
    .mem_rd_data(mem_rd_data)
  );

  // SDRAM controller model
  logic        ack_en;
  logic [3:0]  pv = 4'h0;
  logic [15:0] pd [4];
  logic        wr_pend = 1'b0;
  logic [23:0] wr_addr;
  logic [15:0] mem_m [int];
  int          cyc = 0;

  assign mem_rd_ack   = mem_rd_req & ack_en;
  assign mem_wr_ack   = mem_wr_req & ~mem_rd_req & ack_en;
  assign mem_rd_valid = pv[3];
  assign mem_rd_data  = pd[3];

  function automatic logic [15:0] rdat(input logic [23:0] a);
    if (mem_m.exists(int'(a))) return mem_m[int'(a)];
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [31:0] rd_m(input int a);
    if (mem_m.exists(a)) return {16'h0, mem_m[a]};
    return 32'hDEADDEAD;
  endfunction

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    pv      <= {pv[2:0], mem_rd_ack};
    pd[0]   <= rdat(mem_addr);
    for (int i = 1; i < 4; i++) pd[i] <= pd[i-1];
    wr_pend <= mem_wr_ack;
    wr_addr <= mem_addr;
    if (wr_pend) mem_m[int'(wr_addr)] = mem_wr_data;
  end

  // checking state
  typedef struct { int c; logic [15:0] d; } exp_t;
  exp_t q0[$], q1[$];
  exp_t e;
  int tests = 0, fails = 0;
  int n_val0 = 0, n_val1 = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // per-cycle observation at negedge: read routing, data and latency
  task automatic sample();
    @(negedge clk);
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (c0_rd_ack) q0.push_back('{cyc, c0_addr[15:0] ^ 16'h5A5A});
      if (c1_rd_ack) q1.push_back('{cyc, c1_addr[15:0] ^ 16'h5A5A});
      if (c0_rd_valid) begin
        n_val0++;
        chk("c0_rd_valid_expected", 32'(q0.size() > 0), 1);
        if (q0.size() > 0) begin
          e = q0.pop_front();
          chk("c0_rd_data", c0_rd_data, e.d);
          chk("c0_rd_latency", cyc - e.c, 4);
        end
      end
      if (c1_rd_valid) begin
        n_val1++;
        chk("c1_rd_valid_expected", 32'(q1.size() > 0), 1);
        if (q1.size() > 0) begin
          e = q1.pop_front();
          chk("c1_rd_data", c1_rd_data, e.d);
          chk("c1_rd_latency", cyc - e.c, 4);
        end
      end
      if (mem_rd_valid && !c0_rd_valid) chk("c0_rd_data_zero", c0_rd_data, 0);
      if (mem_rd_valid && !c1_rd_valid) chk("c1_rd_data_zero", c1_rd_data, 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      sample();
      tick();
    end
  endtask

  initial begin
    #300000;
    $error("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  int idx, i0, i1, s0, s1, own, expo;
  logic acc;

  initial begin
    rst = 1'b1; ack_en = 1'b1;
    c0_addr = '0; c0_rd_req = 0; c0_wr_req = 0; c0_wr_data = '0;
    c1_addr = '0; c1_rd_req = 0; c1_wr_req = 0; c1_wr_data = '0;
    wait_cyc(1);
    sample();
    chk("rst_flags", {c0_rd_ack, c0_wr_ack, c0_rd_valid, c1_rd_ack,
                      c1_wr_ack, c1_rd_valid, mem_rd_req, mem_wr_req}, 0);
    chk("rst_rdata", {c0_rd_data, c1_rd_data}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_state", dut.state_q, 0);
    chk("rst_rr", dut.rr_q, 0);
    chk("rst_burst", dut.burst_cnt_q, 0);
    chk("rst_wr_owner", dut.wr_owner_q, 0);
    chk("rst_tags", dut.tag_v_q, 0);
    tick();
    rst = 1'b0;

    // single client streaming reads
    s0 = n_val0; s1 = n_val1; idx = 0;
    c0_addr = 24'h000100; c0_rd_req = 1;
    for (int k = 0; k < 40 && idx < 8; k++) begin
      sample();
      if (c0_rd_ack) idx++;
      tick();
      c0_addr = 24'h000100 + 24'(idx);
      if (idx == 8) c0_rd_req = 0;
    end
    chk("t1_acks", idx, 8);
    wait_cyc(8);
    chk("t1_c0_valids", n_val0 - s0, 8);
    chk("t1_c1_valids", n_val1 - s1, 0);
    chk("t1_q0_drained", q0.size(), 0);
    chk("t1_state_idle", dut.state_q, 0);

`ifdef ARB_PRIORITY_EN
    // c1 streaming, c0 arrives: one IDLE cycle then OWN0
    idx = 0; c1_addr = 24'h000700; c1_rd_req = 1;
    for (int k = 0; k < 40 && idx < 3; k++) begin
      sample();
      if (c1_rd_ack) idx++;
      tick();
    end
    c0_addr = 24'h000710; c0_rd_req = 1;
    sample();
    chk("p_req_state_own1", dut.state_q, 2);
    tick();
    sample();
    chk("p_next_state_idle", dut.state_q, 0);
    tick();
    sample();
    chk("p_then_state_own0", dut.state_q, 1);
    chk("p_c0_ack", c0_rd_ack, 1);
    tick();
    c0_rd_req = 0; c1_rd_req = 0;
    wait_cyc(8);
    chk("p_queues_drained", q0.size() + q1.size(), 0);
`else
    // contention: last owner c0 loses the first tie; 4 accepts per grant
    s0 = n_val0; s1 = n_val1; i0 = 0; i1 = 0;
    c0_addr = 24'h000500; c1_addr = 24'h000600;
    c0_rd_req = 1; c1_rd_req = 1;
    for (int k = 0; k < 15; k++) begin
      sample();
      own = c0_rd_ack ? (c1_rd_ack ? 3 : 0) : (c1_rd_ack ? 1 : 2);
      if (k == 0 || (k - 1) % 5 == 4) expo = 2;
      else expo = (((k - 1) / 5) % 2 == 0) ? 1 : 0;
      chk($sformatf("t2_grant_%0d", k), own, expo);
      if (c0_rd_ack) i0++;
      if (c1_rd_ack) i1++;
      tick();
      c0_addr = 24'h000500 + 24'(i0);
      c1_addr = 24'h000600 + 24'(i1);
    end
    c0_rd_req = 0; c1_rd_req = 0;
    wait_cyc(8);
    chk("t2_c0_valids", n_val0 - s0, 4);
    chk("t2_c1_valids", n_val1 - s1, 8);
    chk("t2_queues_drained", q0.size() + q1.size(), 0);
    chk("t2_no_err", dut.err_q, 0);
`endif

    // c0 reads in flight while c1 takes the port for a write
    s0 = n_val0; idx = 0;
    c0_addr = 24'h000400; c0_rd_req = 1;
    for (int k = 0; k < 40 && idx < 2; k++) begin
      sample();
      if (c0_rd_ack) idx++;
      tick();
      c0_addr = 24'h000400 + 24'(idx);
      if (idx == 2) begin
        c0_rd_req = 0;
        c1_wr_req = 1; c1_addr = 24'h000200; c1_wr_data = 16'hDEAD;
      end
    end
    acc = 0;
    for (int k = 0; k < 40 && !acc; k++) begin
      sample();
      acc = c1_wr_ack;
      tick();
      if (acc) begin
        c1_wr_req = 0; c1_wr_data = 16'hBEEF;
      end
    end
    chk("t3_wr_ack_seen", acc, 1);
    sample();
    chk("t3_mem_wr_data", mem_wr_data, 16'hBEEF);
    tick();
    c1_wr_data = 16'h0000;
    wait_cyc(8);
    chk("t3_c0_valids", n_val0 - s0, 2);
    chk("t3_mem_beef", rd_m(32'h200), 32'h0000BEEF);
    chk("t3_wr_owner", dut.wr_owner_q, 1);

    // c1 write burst with controller stalls
    idx = 0; c1_addr = 24'h000300; c1_wr_req = 1;
    for (int k = 0; k < 60 && idx < 8; k++) begin
      sample();
      acc = c1_wr_ack;
      if (acc) idx++;
      tick();
      if (acc) c1_wr_data = 16'h1111 + 16'(idx - 1);
      c1_addr = 24'h000300 + 24'(idx);
      ack_en = (k % 3 != 1);
      if (idx == 8) c1_wr_req = 0;
    end
    ack_en = 1;
    wait_cyc(4);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t4_mem_%0d", i), rd_m(32'h300 + i), 32'h1111 + i);
    chk("t4_wr_owner", dut.wr_owner_q, 1);

    // reset with 3 reads in flight drops them
    idx = 0; c0_addr = 24'h000800; c0_rd_req = 1;
    for (int k = 0; k < 40 && idx < 3; k++) begin
      sample();
      if (c0_rd_ack) idx++;
      tick();
      c0_addr = 24'h000800 + 24'(idx);
      if (idx == 3) begin
        c0_rd_req = 0; rst = 1;
      end
    end
    s0 = n_val0; s1 = n_val1;
    sample();
    tick();
    rst = 0;
    sample();
    chk("t5_flags", {c0_rd_ack, c0_wr_ack, c0_rd_valid, c1_rd_ack,
                     c1_wr_ack, c1_rd_valid, mem_rd_req, mem_wr_req}, 0);
    chk("t5_rdata", {c0_rd_data, c1_rd_data}, 0);
    chk("t5_state_idle", dut.state_q, 0);
    chk("t5_tags_clear", dut.tag_v_q, 0);
    tick();
    wait_cyc(8);
    chk("t5_no_c0_valid", n_val0 - s0, 0);
    chk("t5_no_c1_valid", n_val1 - s1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
